// File: rtl/fios_operand_io.sv
// Operand feeder and result collector behind the FIOS multiplier strobe interface.
// The host loads A/B/P word-serially; RES words are captured in RUN and drained in READ.
module fios_operand_io #(
  parameter int WORD_WIDTH = 17,
  parameter int s          = 8,
  parameter int PE_NB      = 8
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        load_valid_i,
  input  logic [1:0]                  load_sel_i,
  input  logic [WORD_WIDTH-1:0]       load_data_i,
  output logic                        load_ready_o,
  input  logic                        start_req_i,
  output logic                        start_o,
  output logic [PE_NB*WORD_WIDTH-1:0] a_o,
  output logic [WORD_WIDTH-1:0]       b_o,
  output logic [WORD_WIDTH-1:0]       p_o,
  input  logic                        a_shift_i,
  input  logic                        b_fetch_i,
  input  logic                        p_fetch_i,
  input  logic                        RES_push_i,
  input  logic [WORD_WIDTH-1:0]       RES_i,
  input  logic                        done_i,
  output logic                        res_valid_o,
  output logic [WORD_WIDTH-1:0]       res_data_o,
  input  logic                        res_ready_i,
  output logic                        busy_o,
  output logic                        overflow_o
);

  localparam int NCH = (s + PE_NB - 1) / PE_NB;
  localparam int IW  = (s > 1) ? $clog2(s) : 1;
  localparam int CW  = $clog2(s + 1);
  localparam int KW  = $clog2(NCH + 1);

  localparam logic [IW-1:0] ONE_I  = IW'(1'b1);
  localparam logic [IW-1:0] LAST_I = IW'(s - 32'sd1);
  localparam logic [CW-1:0] ONE_C  = CW'(1'b1);
  localparam logic [CW-1:0] S_C    = CW'(s);
  localparam logic [KW-1:0] ONE_K  = KW'(1'b1);
  localparam logic [KW-1:0] K_MAX  = KW'(NCH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    READ = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [WORD_WIDTH-1:0]   a_buf_r [s];
  logic [WORD_WIDTH-1:0]   b_buf_r [s];
  logic [WORD_WIDTH-1:0]   p_buf_r [s];
  logic [WORD_WIDTH-1:0]   r_buf_r [s];
  logic [2:0][IW-1:0]      wcnt_r;
  logic [2:0]              loaded_r;
  logic [KW-1:0]           a_k_r, a_k_s;
  logic [IW-1:0]           b_idx_r, b_idx_s, p_idx_r, p_idx_s;
  logic [CW-1:0]           res_widx_r, res_widx_s, res_ridx_r, res_ridx_s;
  logic                    overflow_r, overflow_s;
  logic                    start_fire_s, load_fire_s, push_wr_s;

  logic [PE_NB*WORD_WIDTH-1:0] a_r, a_chunk_s;
  logic [WORD_WIDTH-1:0]       b_r, b_word_s, p_r, p_word_s, res_data_r, r_word_s;
  logic                        start_r, busy_r, load_ready_r, res_valid_r;

  // Next-state, index and handshake decode
  always_comb begin
    state_s      = state_r;
    a_k_s        = a_k_r;
    b_idx_s      = b_idx_r;
    p_idx_s      = p_idx_r;
    res_widx_s   = res_widx_r;
    res_ridx_s   = res_ridx_r;
    overflow_s   = overflow_r;
    start_fire_s = 1'b0;
    push_wr_s    = 1'b0;
    load_fire_s  = load_valid_i & load_ready_r;
    case (state_r)
      IDLE: begin
        if (start_req_i && (&loaded_r)) begin
          state_s      = RUN;
          start_fire_s = 1'b1;
          a_k_s        = '0;
          b_idx_s      = '0;
          p_idx_s      = '0;
          res_widx_s   = '0;
          res_ridx_s   = '0;
          overflow_s   = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (a_shift_i && (a_k_r != K_MAX)) begin
          a_k_s = a_k_r + ONE_K;
        end else begin
          a_k_s = a_k_r;
        end
        if (b_fetch_i) begin
          b_idx_s = (b_idx_r == LAST_I) ? '0 : b_idx_r + ONE_I;
        end else begin
          b_idx_s = b_idx_r;
        end
        if (p_fetch_i) begin
          p_idx_s = (p_idx_r == LAST_I) ? '0 : p_idx_r + ONE_I;
        end else begin
          p_idx_s = p_idx_r;
        end
        // A push coinciding with done is still captured before the switch to READ
        if (RES_push_i && (res_widx_r != S_C)) begin
          push_wr_s  = 1'b1;
          res_widx_s = res_widx_r + ONE_C;
        end else if (RES_push_i) begin
          overflow_s = 1'b1;
        end else begin
          res_widx_s = res_widx_r;
        end
        if (done_i) begin
          state_s = READ;
        end else begin
          state_s = RUN;
        end
      end
      READ: begin
        if (res_widx_r == '0) begin
          state_s = IDLE;
        end else if (res_valid_r && res_ready_i) begin
          res_ridx_s = res_ridx_r + ONE_C;
          if (res_ridx_s == res_widx_r) begin
            state_s = IDLE;
          end else begin
            state_s = READ;
          end
        end else begin
          state_s = READ;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Words for the output registers, forwarding a same-cycle write into the slot being read
  always_comb begin
    int idx;
    idx       = 0;
    a_chunk_s = '0;
    for (int j = 0; j < PE_NB; j++) begin
      idx = int'(a_k_s) * PE_NB + j;
      if ((idx < s) && load_fire_s && (load_sel_i == 2'd0) && (int'(wcnt_r[0]) == idx)) begin
        a_chunk_s[j*WORD_WIDTH +: WORD_WIDTH] = load_data_i;
      end else if (idx < s) begin
        a_chunk_s[j*WORD_WIDTH +: WORD_WIDTH] = a_buf_r[IW'(idx)];
      end else begin
        a_chunk_s[j*WORD_WIDTH +: WORD_WIDTH] = '0;
      end
    end
    if (load_fire_s && (load_sel_i == 2'd1) && (wcnt_r[1] == b_idx_s)) begin
      b_word_s = load_data_i;
    end else begin
      b_word_s = b_buf_r[b_idx_s];
    end
    if (load_fire_s && (load_sel_i == 2'd2) && (wcnt_r[2] == p_idx_s)) begin
      p_word_s = load_data_i;
    end else begin
      p_word_s = p_buf_r[p_idx_s];
    end
    if (push_wr_s && (res_widx_r == res_ridx_s)) begin
      r_word_s = RES_i;
    end else begin
      r_word_s = r_buf_r[IW'(res_ridx_s)];
    end
  end

  // FSM state, indices and load bookkeeping
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_r    <= IDLE;
      a_k_r      <= '0;
      b_idx_r    <= '0;
      p_idx_r    <= '0;
      res_widx_r <= '0;
      res_ridx_r <= '0;
      overflow_r <= 1'b0;
      wcnt_r     <= '0;
      loaded_r   <= '0;
    end else begin
      state_r    <= state_s;
      a_k_r      <= a_k_s;
      b_idx_r    <= b_idx_s;
      p_idx_r    <= p_idx_s;
      res_widx_r <= res_widx_s;
      res_ridx_r <= res_ridx_s;
      overflow_r <= overflow_s;
      if (load_fire_s && (load_sel_i != 2'd3)) begin
        if (wcnt_r[load_sel_i] == LAST_I) begin
          wcnt_r[load_sel_i]   <= '0;
          loaded_r[load_sel_i] <= 1'b1;
        end else begin
          wcnt_r[load_sel_i] <= wcnt_r[load_sel_i] + ONE_I;
        end
      end
    end
  end

  // Operand and result storage; contents are intentionally left unreset
  always_ff @(posedge clock_i) begin
    if (load_fire_s) begin
      case (load_sel_i)
        2'd0:    a_buf_r[wcnt_r[0]] <= load_data_i;
        2'd1:    b_buf_r[wcnt_r[1]] <= load_data_i;
        2'd2:    p_buf_r[wcnt_r[2]] <= load_data_i;
        default: ;
      endcase
    end
    if (push_wr_s) begin
      r_buf_r[IW'(res_widx_r)] <= RES_i;
    end
  end

  // Output registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      a_r          <= '0;
      b_r          <= '0;
      p_r          <= '0;
      start_r      <= 1'b0;
      busy_r       <= 1'b0;
      load_ready_r <= 1'b1;
      res_valid_r  <= 1'b0;
      res_data_r   <= '0;
    end else begin
      a_r          <= a_chunk_s;
      b_r          <= b_word_s;
      p_r          <= p_word_s;
      start_r      <= start_fire_s;
      busy_r       <= (state_s != IDLE);
      load_ready_r <= (state_s == IDLE);
      res_valid_r  <= (state_s == READ) && (res_ridx_s < res_widx_s);
      res_data_r   <= r_word_s;
    end
  end

  assign load_ready_o = load_ready_r;
  assign start_o      = start_r;
  assign a_o          = a_r;
  assign b_o          = b_r;
  assign p_o          = p_r;
  assign res_valid_o  = res_valid_r;
  assign res_data_o   = res_data_r;
  assign busy_o       = busy_r;
  assign overflow_o   = overflow_r;

endmodule
